mmio_bridge: RTL and testbench

CPU-side master for the shared memory-mapped peripheral bus. It accepts one load/store at a time from the core's data port over a valid/ready handshake and drives the bus strobes, address and write data. It captures the peripheral's `ack_i`/`data_i` response, or ends the access with an error after a bounded timeout. It sits directly upstream of every MMIO peripheral, including the LED register at 32'h4000_0000.

---
 rtl/mmio_pkg.sv | 17 +
 rtl/mmio_bridge.sv | 113 +++++++++++
 tb/tb_mmio_bridge.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types and constants for the MMIO bridge
// Contents:
//   mmio_state_t       : bridge FSM state encoding
//   LED_BASE           : base address of the LED register peripheral
//   ERR_RDATA_DEFAULT  : load data returned when an access times out
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } mmio_state_t;

    localparam logic [31:0] LED_BASE          = 32'h4000_0000;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - single-outstanding CPU load/store master for the MMIO bus
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cpu_valid_i / cpu_ready_o       : request handshake from the core data port
//   cpu_we_i, cpu_addr_i, cpu_wdata_i : request fields (1 = store)
//   cpu_done_o, cpu_err_o           : one-cycle completion pulse, timeout flag
//   cpu_rdata_o                     : load data, held until the next completion
//   write_o, read_o, addr_o, data_o : bus strobes, address and write data
//   data_i, ack_i                   : shared bus response (may float when unselected)
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_valid_i,
    output logic        cpu_ready_o,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_done_o,
    output logic        cpu_err_o,
    output logic [31:0] cpu_rdata_o,
    output logic        write_o,
    output logic        read_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mmio_state_t state, state_n;
    logic [7:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        acked;
    logic        expired;

    // A floating or unknown ack must never complete an access.
    assign acked   = (ack_i === 1'b1);
    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cpu_valid_i) state_n = BUS;
            BUS:     if (acked || expired) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 8'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            cpu_rdata_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_valid_i) begin
                        we_q    <= cpu_we_i;
                        addr_q  <= cpu_addr_i;
                        wdata_q <= cpu_wdata_i;
                        cnt     <= 8'd0;
                    end
                end
                BUS: begin
                    // Ack takes priority over the final timeout cycle.
                    if (acked) begin
                        err_q <= 1'b0;
                        if (!we_q) cpu_rdata_o <= data_i;
                    end else if (expired) begin
                        err_q <= 1'b1;
                        if (!we_q) cpu_rdata_o <= ERR_RDATA;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Everything the bus and CPU see is decoded from registers only, so the
    // async reset drops the strobes immediately and no input reaches the bus
    // combinationally.
    assign cpu_ready_o = (state == IDLE);
    assign cpu_done_o  = (state == RESP);
    assign cpu_err_o   = (state == RESP) && err_q;
    assign write_o     = (state == BUS) && we_q;
    assign read_o      = (state == BUS) && !we_q;
    assign addr_o      = addr_q;
    assign data_o      = wdata_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - scoreboard bench for mmio_bridge with LED and delayed-ack peripherals
module tb_mmio_bridge;
    import mmio_pkg::*;

    localparam int unsigned TO       = 16;
    localparam logic [31:0] DLY_BASE = 32'h4000_1000;
    localparam logic [31:0] UNMAPPED = 32'h5000_0000;
    localparam logic [31:0] DLY_DATA = 32'hCAFE_0123;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid_i;
    logic        cpu_ready_o;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic        cpu_done_o;
    logic        cpu_err_o;
    logic [31:0] cpu_rdata_o;
    logic        write_o;
    logic        read_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        ack_i;

    always #5 clk = ~clk;

    mmio_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid_i(cpu_valid_i), .cpu_ready_o(cpu_ready_o),
        .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_done_o(cpu_done_o), .cpu_err_o(cpu_err_o), .cpu_rdata_o(cpu_rdata_o),
        .write_o(write_o), .read_o(read_o), .addr_o(addr_o), .data_o(data_o),
        .data_i(data_i), .ack_i(ack_i)
    );

    // Peripherals: LED register acks combinationally; delayed model acks on
    // its TO-th strobe cycle; nothing acks unmapped addresses.
    logic [9:0] ledr = 10'd0;
    int         dly_cnt = 0;
    logic       led_sel, dly_sel, led_ack, dly_ack;

    assign led_sel = (write_o || read_o) && (addr_o == LED_BASE);
    assign dly_sel = (write_o || read_o) && (addr_o == DLY_BASE);
    assign led_ack = led_sel;
    assign dly_ack = dly_sel && (dly_cnt == TO - 1);
    assign ack_i   = led_ack || dly_ack;
    assign data_i  = led_ack ? {22'd0, ledr} : (dly_ack ? DLY_DATA : 32'hDEAD_BEEF);

    always @(posedge clk) begin
        if (write_o && addr_o == LED_BASE) ledr <= data_o[9:0];
        dly_cnt <= dly_sel ? dly_cnt + 1 : 0;
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          strobes;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rdata_model = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts strobe cycles of each access and checks every completion.
    int   scnt = 0;
    logic wseen = 1'b0, rseen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            scnt = 0; wseen = 1'b0; rseen = 1'b0;
        end else begin
            if (write_o || read_o) scnt++;
            wseen = wseen | write_o;
            rseen = rseen | read_o;
            if (cpu_done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("err", {31'd0, cpu_err_o}, {31'd0, e.err});
                    check("rdata", cpu_rdata_o, e.rdata);
                    check("strobe_cycles", scnt, e.strobes);
                    check("strobe_kind", {30'd0, wseen, rseen}, {30'd0, e.we, !e.we});
                end
                scnt = 0; wseen = 1'b0; rseen = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic we, input logic err, input logic [31:0] load_data, input int strobes);
        exp_t e;
        if (!we) rdata_model = load_data;
        e.err = err; e.rdata = rdata_model; e.strobes = strobes; e.we = we;
        sb.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
        int w = 0;
        while (!cpu_ready_o && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) check("ready_wait_expired", 32'd0, 32'd1);
        cpu_valid_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
        @(posedge clk); #1;
        cpu_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 200) check("done_wait_expired", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cpu_valid_i = 1'b0; cpu_we_i = 1'b0;
        cpu_addr_i = 32'd0; cpu_wdata_i = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, cpu_ready_o}, 32'd1);
        check("rst_done", {31'd0, cpu_done_o}, 32'd0);
        check("rst_err", {31'd0, cpu_err_o}, 32'd0);
        check("rst_rdata", cpu_rdata_o, 32'd0);
        check("rst_strobes", {30'd0, write_o, read_o}, 32'd0);
        check("rst_addr", addr_o, 32'd0);
        check("rst_data", data_o, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // LED store, then store/load round trip.
        push_exp(1'b1, 1'b0, 32'd0, 1);
        issue(1'b1, LED_BASE, 32'h0000_03FF);
        wait_drain();
        check("ledr_3ff", {22'd0, ledr}, 32'h0000_03FF);
        push_exp(1'b1, 1'b0, 32'd0, 1);
        issue(1'b1, LED_BASE, 32'h0000_0155);
        wait_drain();
        push_exp(1'b0, 1'b0, 32'h0000_0155, 1);
        issue(1'b0, LED_BASE, 32'h0);
        wait_drain();

        // Unmapped load times out; delayed ack on the last cycle still succeeds.
        push_exp(1'b0, 1'b1, 32'h0000_0000, TO);
        issue(1'b0, UNMAPPED, 32'h0);
        wait_drain();
        push_exp(1'b0, 1'b0, DLY_DATA, TO);
        issue(1'b0, DLY_BASE, 32'h0);
        wait_drain();
        // Timed-out store must leave the load data untouched.
        push_exp(1'b1, 1'b1, 32'd0, TO);
        issue(1'b1, UNMAPPED + 32'd4, 32'h1234_5678);
        wait_drain();

        // Second request held through BUS/RESP.
        push_exp(1'b1, 1'b0, 32'd0, 1);
        push_exp(1'b0, 1'b0, 32'h0000_02AA, 1);
        cpu_valid_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = LED_BASE; cpu_wdata_i = 32'h0000_02AA;
        @(posedge clk); #1;
        cpu_we_i = 1'b0; cpu_wdata_i = 32'h0000_0077;
        @(negedge clk);
        check("b2b_c1_ready", {31'd0, cpu_ready_o}, 32'd0);
        check("b2b_c1_write", {31'd0, write_o}, 32'd1);
        check("b2b_c1_data", data_o, 32'h0000_02AA);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_c2_strobes", {30'd0, write_o, read_o}, 32'd0);
        check("b2b_c2_done", {31'd0, cpu_done_o}, 32'd1);
        check("b2b_c2_no_latch", data_o, 32'h0000_02AA);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_c3_ready", {31'd0, cpu_ready_o}, 32'd1);
        check("b2b_c3_strobes", {30'd0, write_o, read_o}, 32'd0);
        @(posedge clk); #1;
        cpu_valid_i = 1'b0;
        @(negedge clk);
        check("b2b_c4_read", {31'd0, read_o}, 32'd1);
        check("b2b_c4_data", data_o, 32'h0000_0077);
        wait_drain();

        // Reset in BUS cycle 3 of a timeout access: no completion expected.
        issue(1'b0, UNMAPPED, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_read_before", {31'd0, read_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {30'd0, write_o, read_o}, 32'd0);
        check("rst_mid_done", {31'd0, cpu_done_o}, 32'd0);
        rdata_model = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid_ready_after", {31'd0, cpu_ready_o}, 32'd1);

        // Re-issue after reset.
        push_exp(1'b1, 1'b0, 32'd0, 1);
        issue(1'b1, LED_BASE, 32'h0000_03C3);
        wait_drain();
        check("ledr_3c3", {22'd0, ledr}, 32'h0000_03C3);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
